timer_alarm_scheduler: RTL

//  Avalon-MM slave owning one free-running 32-bit tick counter and NUM_CH compare-match alarm channels.

---
 rtl/timer_alarm_scheduler_if.sv | 32 +++
 rtl/timer_alarm_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/timer_alarm_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_alarm_scheduler_if
// Brief    : Avalon-MM slave bus bundle for the timer alarm scheduler.
// Revision : 1.0
// ============================================================================
interface timer_alarm_scheduler_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] avalon_slave_address;
    logic              avalon_slave_read;
    logic [31:0]       avalon_slave_readdata;
    logic              avalon_slave_write;
    logic [31:0]       avalon_slave_writedata;

    modport master (
        output avalon_slave_address,
        output avalon_slave_read,
        output avalon_slave_write,
        output avalon_slave_writedata,
        input  avalon_slave_readdata
    );

    modport slave (
        input  avalon_slave_address,
        input  avalon_slave_read,
        input  avalon_slave_write,
        input  avalon_slave_writedata,
        output avalon_slave_readdata
    );
endinterface
`default_nettype wire

// File: rtl/timer_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : timer_alarm_scheduler
// Brief    : Prescaled 32-bit tick counter with NUM_CH one-shot/periodic
//            compare alarms and a maskable level IRQ. Optional overrun
//            register enabled by TIMER_SCHED_OVERRUN_EN.
// Revision : 1.0
// ============================================================================
module timer_alarm_scheduler #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 4
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    timer_alarm_scheduler_if.slave       bus,
    output logic                         irq
);
    localparam logic [ADDR_W-1:0] c_addr_ctrl  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_addr_presc = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_now   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_addr_pend  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_addr_mask  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_addr_ovr   = ADDR_W'(5);

    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              wr;
    logic              rd;

    logic              en;
    logic [31:0]       prescale;
    logic [31:0]       pcnt;
    logic [31:0]       now;
    logic [31:0]       now_inc;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] armed;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] wr_cmp;
    logic [NUM_CH-1:0] wr_per;
    logic [31:0]       cmp [NUM_CH];
    logic [31:0]       per [NUM_CH];
    logic [31:0]       rdata;
    logic [31:0]       readdata;
    logic              wr_ctrl;
    logic              run;
    logic              tick;

    assign addr    = bus.avalon_slave_address;
    assign wdata   = bus.avalon_slave_writedata;
    assign wr      = bus.avalon_slave_write;
    assign rd      = bus.avalon_slave_read;
    assign bus.avalon_slave_readdata = readdata;

    assign wr_ctrl = wr && (addr == c_addr_ctrl);
    // A disabling CTRL write suppresses the tick in its own cycle too.
    assign run     = en && !(wr_ctrl && !wdata[0]);
    assign tick    = run && (pcnt == prescale);
    assign now_inc = now + 32'd1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign wr_cmp[c] = wr && (addr == ADDR_W'(8 + 2*c));
        assign wr_per[c] = wr && (addr == ADDR_W'(9 + 2*c));
        assign fire[c]   = tick && armed[c] && (cmp[c] == now_inc);
    end

`ifdef TIMER_SCHED_OVERRUN_EN
    logic [NUM_CH-1:0] ovr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr <= '0;
        end else begin
            ovr <= (ovr & ~((wr && addr == c_addr_ovr) ? wdata[NUM_CH-1:0] : '0))
                 | (fire & pend);
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            c_addr_ctrl:  rdata[0] = en;
            c_addr_presc: rdata = prescale;
            c_addr_now:   rdata = now;
            c_addr_pend:  rdata[NUM_CH-1:0] = pend;
            c_addr_mask:  rdata[NUM_CH-1:0] = mask;
`ifdef TIMER_SCHED_OVERRUN_EN
            c_addr_ovr:   rdata[NUM_CH-1:0] = ovr;
`endif
            default:      rdata = '0;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr == ADDR_W'(8 + 2*c)) rdata = cmp[c];
            if (addr == ADDR_W'(9 + 2*c)) rdata = per[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            en       <= 1'b0;
            prescale <= '0;
            pcnt     <= '0;
            now      <= '0;
            pend     <= '0;
            mask     <= '0;
            armed    <= '0;
            irq      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                cmp[c] <= '0;
                per[c] <= '0;
            end
        end else begin
            if (rd) readdata <= rdata;
            if (wr_ctrl) en <= wdata[0];
            if (wr && addr == c_addr_presc) prescale <= wdata;
            if (wr && addr == c_addr_mask) mask <= wdata[NUM_CH-1:0];

            if (!run)      pcnt <= '0;
            else if (tick) pcnt <= '0;
            else           pcnt <= pcnt + 32'd1;

            if (tick)                            now <= now_inc;
            else if (wr && addr == c_addr_now && !en) now <= wdata;

            // Fire sets dominate a same-cycle W1C.
            pend <= (pend & ~((wr && addr == c_addr_pend) ? wdata[NUM_CH-1:0] : '0))
                  | fire;
            irq  <= |(pend & mask);

            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_cmp[c]) begin
                    cmp[c]   <= wdata;
                    armed[c] <= 1'b1;
                end else if (fire[c]) begin
                    if (per[c] != 32'd0) cmp[c] <= cmp[c] + per[c];
                    else                 armed[c] <= 1'b0;
                end
                if (wr_per[c]) per[c] <= wdata;
            end
        end
    end
endmodule
`default_nettype wire
